// File: rtl/avg_controller.sv
// avg_controller: Moore FSM that sequences the 4-sample averager datapath and sample counter.
// Define AVG_CTRL_OVERRUN_EN to abort a sample to EIDLE when overrun is seen in STORE.
module avg_controller #(
  parameter int ADDR_W   = 4,
  parameter int SMPL_REG = 5,
  parameter int ACC_REG  = 0
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              dr,
  input  logic              overrun,
  input  logic              one_k_samples,
  output logic              cnt_up,
  output logic              clear,
  output logic              modwait,
  output logic [2:0]        op,
  output logic [ADDR_W-1:0] src1,
  output logic [ADDR_W-1:0] src2,
  output logic [ADDR_W-1:0] dest,
  output logic              err,
  output logic [3:0]        dbg_state
);

  // Handshake: dr is a level; a sample is accepted only on its rising edge in IDLE/EIDLE, and the
  // source must keep dr high through STORE and must not raise dr while modwait is high.

  localparam logic [3:0] IDLE  = 4'd0;
  localparam logic [3:0] STORE = 4'd1;
  localparam logic [3:0] SORT1 = 4'd2;
  localparam logic [3:0] SORT2 = 4'd3;
  localparam logic [3:0] SORT3 = 4'd4;
  localparam logic [3:0] SORT4 = 4'd5;
  localparam logic [3:0] ADD1  = 4'd6;
  localparam logic [3:0] ADD2  = 4'd7;
  localparam logic [3:0] ADD3  = 4'd8;
  localparam logic [3:0] CLR   = 4'd9;
  localparam logic [3:0] EIDLE = 4'd10;

  // The ALU also decodes SUB (5); this sequence never issues it.
  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_COPY = 3'd1;
  localparam logic [2:0] OP_LOAD = 3'd2;
  localparam logic [2:0] OP_ADD  = 3'd4;

  localparam logic [ADDR_W-1:0] R1   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] R2   = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] R3   = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] R4   = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] RSMP = ADDR_W'(SMPL_REG);
  localparam logic [ADDR_W-1:0] RACC = ADDR_W'(ACC_REG);

  logic [3:0] state_q, state_d;
  logic       dr_q;
  logic       modwait_q, modwait_d;
  logic       start;
  logic       store_abort;

  assign start = dr & ~dr_q;

`ifdef AVG_CTRL_OVERRUN_EN
  assign store_abort = overrun | ~dr;
`else
  logic unused_overrun;
  assign unused_overrun = overrun;
  assign store_abort    = ~dr;
`endif

  always_comb begin
    state_d = state_q;
    op      = OP_NOP;
    src1    = '0;
    src2    = '0;
    dest    = '0;
    cnt_up  = 1'b0;
    clear   = 1'b0;
    err     = 1'b0;
    case (state_q)
      IDLE:  if (start) state_d = STORE;
      STORE: begin
        op      = OP_LOAD;
        dest    = RSMP;
        state_d = store_abort ? EIDLE : SORT1;
      end
      SORT1: begin
        op = OP_COPY; src1 = R3; dest = R4; cnt_up = 1'b1;
        state_d = SORT2;
      end
      SORT2: begin
        op = OP_COPY; src1 = R2; dest = R3;
        state_d = SORT3;
      end
      SORT3: begin
        op = OP_COPY; src1 = R1; dest = R2;
        state_d = SORT4;
      end
      SORT4: begin
        op = OP_COPY; src1 = RSMP; dest = R1;
        state_d = ADD1;
      end
      ADD1: begin
        op = OP_ADD; src1 = R1; src2 = R2; dest = RACC;
        state_d = ADD2;
      end
      ADD2: begin
        op = OP_ADD; src1 = RACC; src2 = R3; dest = RACC;
        state_d = ADD3;
      end
      ADD3: begin
        op = OP_ADD; src1 = RACC; src2 = R4; dest = RACC;
        state_d = one_k_samples ? CLR : IDLE;
      end
      CLR: begin
        clear   = 1'b1;
        state_d = IDLE;
      end
      EIDLE: begin
        err = 1'b1;
        if (start) state_d = STORE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign modwait_d = (state_d != IDLE) && (state_d != EIDLE);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      dr_q      <= 1'b0;
      modwait_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dr_q      <= dr;
      modwait_q <= modwait_d;
    end
  end

  assign modwait   = modwait_q;
  assign dbg_state = state_q;

endmodule
